// File: rtl/instruction_loader_pkg.sv
// rtl/instruction_loader_pkg.sv - shared types and constants for the instruction loader
package instruction_loader_pkg;

  localparam int DEPTH_DEF = 11;
  localparam int INSTR_W   = 32;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_LOAD  = 2'd1,
    ST_WRITE = 2'd2,
    ST_DONE  = 2'd3
  } state_t;

endpackage

// File: rtl/instruction_loader_byte_assembler.sv
// rtl/instruction_loader_byte_assembler.sv - little-endian byte-to-word assembly register
module instruction_loader_byte_assembler
  import instruction_loader_pkg::*;
(
  input  logic               i_clock,
  input  logic               i_reset,
  input  logic               i_clear,
  input  logic               i_push,
  input  logic [7:0]         i_byte,
  input  logic               i_last,
  output logic [INSTR_W-1:0] o_word_next,
  output logic               o_complete
);

  logic [INSTR_W-1:0] r_word;
  logic [1:0]         r_byte_cnt;
  logic [INSTR_W-1:0] w_word_next;

  // Register is cleared between words, so a short final word is already zero-padded.
  always_comb begin
    w_word_next = r_word;
    w_word_next[8*r_byte_cnt +: 8] = i_byte;
  end

  assign o_word_next = w_word_next;
  assign o_complete  = i_push & ((r_byte_cnt == 2'd3) | i_last);

  always_ff @(posedge i_clock) begin
    if (i_reset || i_clear) begin
      r_word     <= '0;
      r_byte_cnt <= '0;
    end else if (i_push) begin
      r_word     <= w_word_next;
      r_byte_cnt <= r_byte_cnt + 2'd1;
    end
  end

endmodule

// File: rtl/instruction_loader.sv
// rtl/instruction_loader.sv - fills instruction memory from a byte stream, one write per word
module instruction_loader
  import instruction_loader_pkg::*;
#(
  parameter int DEPTH  = DEPTH_DEF,
  parameter int ADDR_W = 4
) (
  input  logic               i_clock,
  input  logic               i_reset,
  input  logic               i_start,
  input  logic [7:0]         i_byte_in,
  input  logic               i_byte_valid,
  input  logic               i_byte_last,
  output logic               o_byte_ready,
  output logic               o_mem_we,
  output logic [ADDR_W-1:0]  o_mem_addr,
  output logic [INSTR_W-1:0] o_mem_wdata,
  output logic [ADDR_W:0]    o_words_loaded,
  output logic               o_busy,
  output logic               o_done
);

  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(DEPTH - 1);

  state_t             r_state;
  logic               r_byte_ready;
  logic               r_mem_we;
  logic [ADDR_W-1:0]  r_mem_addr;
  logic [INSTR_W-1:0] r_mem_wdata;
  logic [ADDR_W:0]    r_words_loaded;
  logic [ADDR_W-1:0]  r_word_addr;
  logic               r_busy;
  logic               r_done;
  logic               r_final_last;

  logic               w_transfer;
  logic               w_start_ok;
  logic               w_clear;
  logic               w_complete;
  logic [INSTR_W-1:0] w_word_next;

  // byte_ready is only ever high in LOAD, so it alone qualifies a transfer.
  assign w_transfer = i_byte_valid & r_byte_ready;
  assign w_start_ok = i_start & ((r_state == ST_IDLE) | (r_state == ST_DONE));
  assign w_clear    = w_start_ok | (r_state == ST_WRITE);

  instruction_loader_byte_assembler u_assembler (
    .i_clock     (i_clock),
    .i_reset     (i_reset),
    .i_clear     (w_clear),
    .i_push      (w_transfer),
    .i_byte      (i_byte_in),
    .i_last      (i_byte_last),
    .o_word_next (w_word_next),
    .o_complete  (w_complete)
  );

  always_ff @(posedge i_clock) begin
    if (i_reset) begin
      r_state        <= ST_IDLE;
      r_byte_ready   <= 1'b0;
      r_mem_we       <= 1'b0;
      r_mem_addr     <= '0;
      r_mem_wdata    <= '0;
      r_words_loaded <= '0;
      r_word_addr    <= '0;
      r_busy         <= 1'b0;
      r_done         <= 1'b0;
      r_final_last   <= 1'b0;
    end else begin
      case (r_state)
        ST_IDLE, ST_DONE: begin
          if (i_start) begin
            r_state        <= ST_LOAD;
            r_byte_ready   <= 1'b1;
            r_busy         <= 1'b1;
            r_done         <= 1'b0;
            r_word_addr    <= '0;
            r_words_loaded <= '0;
            r_final_last   <= 1'b0;
          end
        end
        ST_LOAD: begin
          if (w_complete) begin
            r_state      <= ST_WRITE;
            r_byte_ready <= 1'b0;
            r_mem_we     <= 1'b1;
            r_mem_addr   <= r_word_addr;
            r_mem_wdata  <= w_word_next;
            r_final_last <= i_byte_last;
          end
        end
        ST_WRITE: begin
          r_mem_we       <= 1'b0;
          r_word_addr    <= r_word_addr + 1'b1;
          r_words_loaded <= r_words_loaded + 1'b1;
          // A full memory ends the session even if the source never signals last.
          if (r_final_last || (r_word_addr == LAST_ADDR)) begin
            r_state <= ST_DONE;
            r_busy  <= 1'b0;
            r_done  <= 1'b1;
          end else begin
            r_state      <= ST_LOAD;
            r_byte_ready <= 1'b1;
          end
        end
        default: begin
          r_state      <= ST_IDLE;
          r_byte_ready <= 1'b0;
          r_mem_we     <= 1'b0;
          r_busy       <= 1'b0;
          r_done       <= 1'b0;
        end
      endcase
    end
  end

  assign o_byte_ready   = r_byte_ready;
  assign o_mem_we       = r_mem_we;
  assign o_mem_addr     = r_mem_addr;
  assign o_mem_wdata    = r_mem_wdata;
  assign o_words_loaded = r_words_loaded;
  assign o_busy         = r_busy;
  assign o_done         = r_done;

endmodule

// File: tb/tb_instruction_loader.sv
// tb/tb_instruction_loader.sv - directed vector bench for instruction_loader
module tb_instruction_loader;

  logic        clk = 1'b0;
  logic        i_reset = 1'b1;
  logic        i_start = 1'b0;
  logic [7:0]  i_byte_in = 8'h00;
  logic        i_byte_valid = 1'b0;
  logic        i_byte_last = 1'b0;
  logic        o_byte_ready;
  logic        o_mem_we;
  logic [3:0]  o_mem_addr;
  logic [31:0] o_mem_wdata;
  logic [4:0]  o_words_loaded;
  logic        o_busy;
  logic        o_done;

  int checks = 0;
  int failures = 0;

  logic [3:0]  wr_addr[$];
  logic [31:0] wr_data[$];
  int          double_we = 0;
  logic        prev_we = 1'b0;

  always #5 clk = ~clk;

  instruction_loader dut (
    .i_clock        (clk),
    .i_reset        (i_reset),
    .i_start        (i_start),
    .i_byte_in      (i_byte_in),
    .i_byte_valid   (i_byte_valid),
    .i_byte_last    (i_byte_last),
    .o_byte_ready   (o_byte_ready),
    .o_mem_we       (o_mem_we),
    .o_mem_addr     (o_mem_addr),
    .o_mem_wdata    (o_mem_wdata),
    .o_words_loaded (o_words_loaded),
    .o_busy         (o_busy),
    .o_done         (o_done)
  );

  always @(negedge clk) begin
    if (o_mem_we) begin
      wr_addr.push_back(o_mem_addr);
      wr_data.push_back(o_mem_wdata);
      if (prev_we) double_we++;
    end
    prev_we = o_mem_we;
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic clear_log();
    wr_addr.delete();
    wr_data.delete();
    double_we = 0;
  endtask

  task automatic do_reset();
    @(negedge clk);
    i_reset = 1'b1;
    i_byte_valid = 1'b0;
    i_byte_last = 1'b0;
    i_start = 1'b0;
    @(posedge clk);
    @(posedge clk);
    #1;
    i_reset = 1'b0;
    clear_log();
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_ready"}, 32'(o_byte_ready), 32'd0);
    check({tag, "_we"}, 32'(o_mem_we), 32'd0);
    check({tag, "_addr"}, 32'(o_mem_addr), 32'd0);
    check({tag, "_wdata"}, o_mem_wdata, 32'd0);
    check({tag, "_words"}, 32'(o_words_loaded), 32'd0);
    check({tag, "_busy"}, 32'(o_busy), 32'd0);
    check({tag, "_done"}, 32'(o_done), 32'd0);
  endtask

  task automatic pulse_start();
    @(negedge clk);
    i_start = 1'b1;
    @(posedge clk);
    #1;
    i_start = 1'b0;
  endtask

  task automatic send_byte(input logic [7:0] b, input logic last, input string tag);
    int n = 0;
    @(negedge clk);
    i_byte_in = b;
    i_byte_valid = 1'b1;
    i_byte_last = last;
    while (!o_byte_ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (n >= 50) begin
      checks++;
      failures++;
      $display("FAIL %s_ready_timeout: byte_ready stayed 0 for %0d cycles", tag, n);
    end
    @(posedge clk);
    #1;
    i_byte_valid = 1'b0;
    i_byte_last = 1'b0;
  endtask

  task automatic wait_done(input string tag);
    int n = 0;
    while (!o_done && n < 40) begin
      @(negedge clk);
      n++;
    end
    check({tag, "_done"}, 32'(o_done), 32'd1);
    check({tag, "_busy"}, 32'(o_busy), 32'd0);
  endtask

  typedef struct {
    int          n;
    logic [63:0] bytes;
    bit          tog;
    int          exp_n;
    logic [63:0] exp_w;
  } vec_t;

  vec_t vecs[5];

  initial begin
    logic [63:0] bv;
    logic [63:0] ew;
    logic [31:0] w;
    string       tag;

    vecs[0] = '{8, 64'h00100093_00000013, 1'b0, 2, 64'h00100093_00000013};
    vecs[1] = '{2, 64'h0000_BBAA,          1'b0, 1, 64'h00000000_0000BBAA};
    vecs[2] = '{4, 64'h04030201,           1'b1, 1, 64'h00000000_04030201};
    vecs[3] = '{3, 64'h00332211,           1'b0, 1, 64'h00000000_00332211};
    vecs[4] = '{5, 64'h05_04030201,        1'b0, 2, 64'h00000005_04030201};

    do_reset();
    check_reset_outputs("reset");

    for (int v = 0; v < 5; v++) begin
      tag = $sformatf("vec%0d", v);
      do_reset();
      pulse_start();
      check({tag, "_start_busy"}, 32'(o_busy), 32'd1);
      check({tag, "_start_ready"}, 32'(o_byte_ready), 32'd1);
      bv = vecs[v].bytes;
      for (int i = 0; i < vecs[v].n; i++) begin
        send_byte(bv[8*i +: 8], (i == vecs[v].n - 1), tag);
        if ((i % 4 == 3) || (i == vecs[v].n - 1))
          check($sformatf("%s_we_latency_b%0d", tag, i), 32'(o_mem_we), 32'd1);
        if (vecs[v].tog) @(posedge clk);
      end
      wait_done(tag);
      check({tag, "_nwrites"}, 32'(wr_addr.size()), 32'(vecs[v].exp_n));
      check({tag, "_words"}, 32'(o_words_loaded), 32'(vecs[v].exp_n));
      check({tag, "_single_we"}, 32'(double_we), 32'd0);
      ew = vecs[v].exp_w;
      for (int k = 0; k < vecs[v].exp_n && k < wr_addr.size(); k++) begin
        check($sformatf("%s_addr%0d", tag, k), 32'(wr_addr[k]), 32'(k));
        check($sformatf("%s_data%0d", tag, k), wr_data[k], ew[32*k +: 32]);
      end
    end

    // Full memory: 44 bytes with no last, then a 45th byte must be refused.
    do_reset();
    pulse_start();
    for (int i = 0; i < 44; i++) send_byte(8'(i), 1'b0, "full");
    wait_done("full");
    check("full_nwrites", 32'(wr_addr.size()), 32'd11);
    check("full_words", 32'(o_words_loaded), 32'd11);
    for (int k = 0; k < 11 && k < wr_addr.size(); k++) begin
      w = {8'(4*k+3), 8'(4*k+2), 8'(4*k+1), 8'(4*k)};
      check($sformatf("full_addr%0d", k), 32'(wr_addr[k]), 32'(k));
      check($sformatf("full_data%0d", k), wr_data[k], w);
    end
    @(negedge clk);
    i_byte_in = 8'hEE;
    i_byte_valid = 1'b1;
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      check($sformatf("full_byte45_ready_c%0d", c), 32'(o_byte_ready), 32'd0);
    end
    i_byte_valid = 1'b0;
    check("full_byte45_nwrites", 32'(wr_addr.size()), 32'd11);
    check("full_byte45_done", 32'(o_done), 32'd1);

    // Reset after two bytes of a word: nothing written, outputs back to reset values.
    do_reset();
    pulse_start();
    send_byte(8'h11, 1'b0, "rstmid");
    send_byte(8'h22, 1'b0, "rstmid");
    @(negedge clk);
    i_reset = 1'b1;
    @(posedge clk);
    #1;
    i_reset = 1'b0;
    check_reset_outputs("rstmid");
    check("rstmid_nwrites", 32'(wr_addr.size()), 32'd0);
    pulse_start();
    send_byte(8'hA1, 1'b0, "rstmid2");
    send_byte(8'hB2, 1'b1, "rstmid2");
    wait_done("rstmid2");
    check("rstmid2_nwrites", 32'(wr_addr.size()), 32'd1);
    if (wr_addr.size() > 0) begin
      check("rstmid2_addr0", 32'(wr_addr[0]), 32'd0);
      check("rstmid2_data0", wr_data[0], 32'h0000B2A1);
    end

    // start during LOAD is ignored; start in DONE restarts from address 0.
    do_reset();
    pulse_start();
    send_byte(8'h78, 1'b0, "ldstart");
    pulse_start();
    check("ldstart_busy", 32'(o_busy), 32'd1);
    check("ldstart_ready", 32'(o_byte_ready), 32'd1);
    send_byte(8'h56, 1'b0, "ldstart");
    send_byte(8'h34, 1'b0, "ldstart");
    send_byte(8'h12, 1'b1, "ldstart");
    wait_done("ldstart");
    check("ldstart_nwrites", 32'(wr_addr.size()), 32'd1);
    if (wr_addr.size() > 0) begin
      check("ldstart_addr0", 32'(wr_addr[0]), 32'd0);
      check("ldstart_data0", wr_data[0], 32'h12345678);
    end
    check("ldstart_words", 32'(o_words_loaded), 32'd1);
    clear_log();
    pulse_start();
    check("restart_words", 32'(o_words_loaded), 32'd0);
    check("restart_done", 32'(o_done), 32'd0);
    for (int i = 0; i < 8; i++) send_byte(8'hC0 + 8'(i), (i == 7), "restart");
    wait_done("restart");
    check("restart_nwrites", 32'(wr_addr.size()), 32'd2);
    check("restart_words2", 32'(o_words_loaded), 32'd2);
    if (wr_addr.size() > 1) begin
      check("restart_addr0", 32'(wr_addr[0]), 32'd0);
      check("restart_data0", wr_data[0], 32'hC3C2C1C0);
      check("restart_addr1", 32'(wr_addr[1]), 32'd1);
      check("restart_data1", wr_data[1], 32'hC7C6C5C4);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1);
  end

endmodule
